// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin req/ack arbiter sharing one synchronous RAM between
//             the CPU memory path and the loader/debug port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;
    localparam int   CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              grant;
    logic              grant_ld;
    logic              capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_ld  = 1'b0;
        capture   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        cpu_ack   = 1'b0;
        ld_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || ld_req) begin
                    grant = 1'b1;
                    // On conflict the port that did not win last time goes first.
                    grant_ld  = ld_req && (!cpu_req || (last_grant == PORT_CPU));
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                state_nxt = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cpu_ack   = (owner == PORT_CPU);
                ld_ack    = (owner == PORT_LD);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= PORT_CPU;
            last_grant <= PORT_LD;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
        end else begin
            if (grant) begin
                owner   <= grant_ld;
                we_q    <= grant_ld ? ld_we    : cpu_we;
                addr_q  <= grant_ld ? ld_addr  : cpu_addr;
                wdata_q <= grant_ld ? ld_wdata : cpu_wdata;
            end
            if (state == ACCESS) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (capture) begin
                if (owner == PORT_LD) begin
                    ld_rdata <= ram_rdata;
                end else begin
                    cpu_rdata <= ram_rdata;
                end
            end
            if (state == DONE) begin
                last_grant <= owner;
            end
        end
    end

    // RAM address/data follow the latched request and hold between accesses.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (RD_LAT=1 and RD_LAT=3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
    logic [8:0]  cpu_addr = '0, ld_addr = '0;
    logic [31:0] cpu_wdata = '0, ld_wdata = '0;
    logic        cpu_ack, ld_ack, ram_en, ram_we, busy;
    logic [31:0] cpu_rdata, ld_rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_addr;

    logic        d3_ld_req = 1'b0;
    logic [8:0]  d3_ld_addr = '0;
    logic        d3_cpu_ack, d3_ld_ack, d3_ram_en, d3_ram_we, d3_busy;
    logic [31:0] d3_cpu_rdata, d3_ld_rdata, d3_ram_wdata, d3_ram_rdata;
    logic [8:0]  d3_ram_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_log[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(9'h000), .cpu_wdata(32'h0),
        .cpu_ack(d3_cpu_ack), .cpu_rdata(d3_cpu_rdata),
        .ld_req(d3_ld_req), .ld_we(1'b0), .ld_addr(d3_ld_addr), .ld_wdata(32'h0),
        .ld_ack(d3_ld_ack), .ld_rdata(d3_ld_rdata),
        .ram_en(d3_ram_en), .ram_we(d3_ram_we), .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata),
        .ram_rdata(d3_ram_rdata), .busy(d3_busy)
    );

    // Synchronous RAM, one-cycle read latency.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Three-stage read pipeline; only word 0x0FF holds a non-zero value.
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        if (d3_ram_en) p3[0] <= (d3_ram_addr == 9'h0FF) ? 32'h12345678 : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_ram_rdata = p3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a granted transaction occupies 2 cycles (write)
    // or 2+LAT cycles (read); ram_en in its first, ack in its last.
    logic        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_we = 1'b0;
    int          m_t = 0, m_dur = 0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_crd = '0, m_lrd = '0;
    logic [31:0] shadow [512];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0; m_t = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_crd = '0; m_lrd = '0;
        end else if (!m_busy) begin
            if (cpu_req || ld_req) begin
                m_owner = (cpu_req && ld_req) ? ~m_last : ld_req;
                m_we    = m_owner ? ld_we : cpu_we;
                m_addr  = m_owner ? ld_addr : cpu_addr;
                m_wdata = m_owner ? ld_wdata : cpu_wdata;
                m_dur   = m_we ? 2 : 2 + LAT;
                m_t     = 0;
                m_busy  = 1'b1;
            end
        end else begin
            m_t++;
            if (m_t == m_dur - 1) begin
                if (m_we)         shadow[m_addr] = m_wdata;
                else if (m_owner) m_lrd = shadow[m_addr];
                else              m_crd = shadow[m_addr];
                m_last = m_owner;
            end
            if (m_t == m_dur) m_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        check("busy", busy, m_busy);
        check("ram_en", ram_en, m_busy && m_t == 0);
        check("ram_we", ram_we, m_busy && m_t == 0 && m_we);
        check("ram_addr", ram_addr, m_addr);
        check("ram_wdata", ram_wdata, m_wdata);
        check("cpu_ack", cpu_ack, m_busy && m_t == m_dur - 1 && !m_owner);
        check("ld_ack", ld_ack, m_busy && m_t == m_dur - 1 && m_owner);
        check("cpu_rdata", cpu_rdata, m_crd);
        check("ld_rdata", ld_rdata, m_lrd);
        if (cpu_ack) ack_log.push_back(0);
        if (ld_ack)  ack_log.push_back(1);
    end

    task automatic cpu_txn(input logic we, input logic [8:0] a, input logic [31:0] d, output int lat);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (cpu_ack !== 1'b1 && lat < 60);
        check("cpu_ack_seen", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic ld_txn(input logic we, input logic [8:0] a, input logic [31:0] d, output int lat);
        ld_we = we; ld_addr = a; ld_wdata = d; ld_req = 1'b1; lat = 0;
        do begin @(negedge clk); lat++; end while (ld_ack !== 1'b1 && lat < 60);
        check("ld_ack_seen", ld_ack, 1'b1);
        ld_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, c0, c1;
        // Reset held with both ports requesting.
        cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hC0000000; cpu_req = 1'b1;
        ld_we  = 1'b1; ld_addr  = 9'h000; ld_wdata  = 32'h00000001; ld_req  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_quiet", {ram_en, ram_we, busy, cpu_ack, ld_ack}, 5'b0);
            check("rst_regs", {ram_addr, cpu_rdata, ld_rdata}, 73'h0);
        end
        rst_n = 1'b1;

        // Conflicting streams: CPU must win first, then strict alternation.
        fork
            begin
                int l;
                for (int i = 0; i < 4; i++) cpu_txn(1'b1, 9'h010 + 9'(i), 32'hC0000000 + 32'(i), l);
            end
            begin
                int l;
                for (int i = 0; i < 4; i++) ld_txn(1'b1, 9'(i), 32'(i + 1), l);
            end
            begin
                @(negedge clk);
                check("first_grant_cpu", {ram_en, ram_addr}, {1'b1, 9'h010});
            end
        join
        check("conflict_acks", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size() && i < 8; i++)
            check("conflict_order", ack_log[i], i % 2);

        ld_txn(1'b0, 9'h002, 32'h0, lat);
        check("ld_rd_lat", lat, 3);
        check("ld_rd_data", ld_rdata, 32'h00000003);

        cpu_txn(1'b1, 9'h1A5, 32'hDEADBEEF, lat);
        check("cpu_wr_lat", lat, 2);
        cpu_txn(1'b0, 9'h1A5, 32'h0, lat);
        check("cpu_rd_lat", lat, 3);
        check("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        check("ld_rdata_kept", ld_rdata, 32'h00000003);

        // Loader holds req through its ack: two back-to-back grants.
        ld_we = 1'b1; ld_addr = 9'h050; ld_wdata = 32'h55; ld_req = 1'b1;
        n = 0; c0 = 0; c1 = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (ld_ack) begin
                if (n == 0) c0 = i; else c1 = i;
                n++;
            end
        end
        ld_req = 1'b0;
        check("held_acks", n, 2);
        check("held_spacing", c1 - c0, 3);
        repeat (2) @(negedge clk);

        // RD_LAT=3 instance: loader read of 0x0FF.
        d3_ld_addr = 9'h0FF; d3_ld_req = 1'b1; lat = 0;
        do begin
            @(negedge clk); lat++;
            check("d3_busy", d3_busy, 1'b1);
        end while (d3_ld_ack !== 1'b1 && lat < 30);
        d3_ld_req = 1'b0;
        check("d3_lat", lat, 5);
        check("d3_ld_rdata", d3_ld_rdata, 32'h12345678);
        check("d3_cpu_rdata", d3_cpu_rdata, 32'h0);
        @(negedge clk);
        check("d3_idle", {d3_busy, d3_ld_ack, d3_cpu_ack}, 3'b0);

        // Reset during a CPU write ACCESS must abort the write.
        cpu_we = 1'b1; cpu_addr = 9'h1A5; cpu_wdata = 32'hBAD0BAD0; cpu_req = 1'b1;
        @(posedge clk);
        #2;
        check("abort_pre_we", ram_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_we_drop", ram_we, 1'b0);
        cpu_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ack", cpu_ack, 1'b0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_mem_kept", mem[9'h1A5], 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 512x32 program/data RAM between the CPU datapath memory path (MAR/MDR, driven by Read/Write from the control unit) and an external loader/debug port. Each requester uses a req/ack handshake. The arbiter serialises accesses, applies round-robin priority on conflict, and sequences the RAM's synchronous read latency. It sits between the datapath's MAR/MDR outputs and the RAM instance.

## Interface
- ADDR_W, 9, RAM address width (matches the MAR-to-RAM bus)
- DATA_W, 32, data width
- RD_LAT, 1, RAM read latency in cycles from address edge to data valid (1..3)

- Clock  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held high with fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle and held until the next CPU read completes
- ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata  same as cpu_*, for the loader port
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: sample cpu_req and ld_req.
  - If only one is high, grant it.
  - If both are high, grant the port not granted last. The last-grant register resets to LD, so the CPU wins the first conflict.
  - On grant, latch owner, we, addr and wdata into internal registers and go to ACCESS.
- ACCESS (1 cycle): ram_en=1, ram_addr/ram_wdata driven from the latched registers, ram_we equal to the latched we.
  - Write: next state DONE.
  - Read: next state WAIT. With RD_LAT=1, WAIT lasts 1 cycle.
- WAIT: count RD_LAT cycles with ram_en=0. On the final WAIT edge, capture ram_rdata into the owner's rdata register and go to DONE.
- DONE (1 cycle): owner's ack=1, and the last-grant register is updated. Requests are ignored in DONE. The next state is always IDLE.
- Requester rule: deassert req on the edge at which ack=1 is sampled. A req still high in IDLE afterwards is treated as a new transaction.
- The non-owner's rdata is never modified. A write never changes either rdata register.
- Outside ACCESS: ram_en=0, ram_we=0. ram_addr and ram_wdata hold their last latched values.

## Timing
- Reset (Reset=0, asynchronous) forces:
  - state=IDLE, last-grant=LD;
  - cpu_ack=ld_ack=0, ram_en=ram_we=0, busy=0;
  - ram_addr=0, ram_wdata=0, cpu_rdata=ld_rdata=0.
- Reset asserted mid-ACCESS deasserts ram_we immediately, aborting the write. The in-flight transaction is dropped with no ack, and the requester must re-issue it.
- Write latency: req sampled at edge k, ACCESS in cycle k..k+1, ack high in cycle k+1..k+2. Total 2 cycles from sample to ack.
- Read latency: ack high RD_LAT+1 cycles after the ACCESS edge, i.e. cycle k+1+RD_LAT. With RD_LAT=1, ack appears 3 cycles after the sample.
- Back-to-back: minimum spacing between grants is 3 cycles for writes (IDLE, ACCESS, DONE) and 3+RD_LAT cycles for reads.
- Arbitration under continuous dual requests strictly alternates, so neither port waits more than one transaction.
- A request arriving while busy is held by the requester and served at the next IDLE. The arbiter does not queue requests.
- ack is never high for more than one cycle and never high for both ports in the same cycle.
- ram_en is high for exactly one cycle per transaction.

## Test plan
- Reset: hold Reset=0 for 3 cycles with both req high -> all outputs 0, no ram_en pulse; release -> CPU granted first on the next edge.
- CPU write then read: write 0xDEADBEEF to 0x1A5 -> ram_we=1 for one cycle with ram_addr=0x1A5, cpu_ack 2 cycles after sample. Then read 0x1A5 -> cpu_ack 3 cycles after sample with cpu_rdata=0xDEADBEEF, and ld_rdata unchanged.
- Conflict: cpu_req and ld_req raised on the same edge for 4 transactions each (loader writes 0x00000001..4 to 0x000..0x003) -> grants alternate CPU, LD, CPU, ...; never two acks in one cycle.
- Held req: loader keeps ld_req high through its ack -> exactly one DONE per sample, second transaction starts in the next IDLE; ld_ack pulses are each 1 cycle wide.
- RD_LAT=3 build: read from 0x0FF containing 0x12345678 -> ld_ack 4 cycles after the ACCESS edge, ld_rdata=0x12345678, busy high throughout.
- Reset mid-op: drop Reset during CPU write ACCESS -> ram_we falls within the same cycle, no cpu_ack, and the RAM word at the target address is unchanged.
